llc_flush_seq: RTL
==================

# llc_flush_seq

Configuration-port sequencer that sits directly upstream of the LLC's RegBus configuration interface. On a single-cycle request it flushes a selected set of LLC ways: it writes the way mask to the flush register, commits the configuration, then polls the flushed-status register until every requested way reports flushed. It replaces software-driven flush sequences for hardware agents such as power management or partition reconfiguration.

## Interface
- `SetAssociativity`, default 8: number of LLC ways; legal range 1..32; sets the mask width.
- `BaseAddr`, default 32'h0: RegBus base address of the LLC configuration registers.
- `FlushRegOffset`, default 32'h10: offset of the flush-ways register (low 32 bits).
- `CommitRegOffset`, default 32'h18: offset of the commit register.
- `FlushedRegOffset`, default 32'h20: offset of the flushed-status register (low 32 bits).
- `PollGap`, default 16: idle cycles between status reads; legal range ≥1.
- `TimeoutCycles`, default 4096: poll budget in cycles; present only with the timeout macro.

Ports:
- `clk_i`  in  1  clock; all logic is on the rising edge.
- `rst_i`  in  1  asynchronous, active-high reset.
- `flush_req_i`  in  1  single-cycle start request.
- `flush_mask_i`  in  SetAssociativity  ways to flush; sampled with the request.
- `busy_o`  out  1  high from acceptance until the `done_o` cycle inclusive.
- `done_o`  out  1  one-cycle completion pulse; asserted for success and failure.
- `err_o`  out  1  sticky RegBus error flag; cleared by the next accepted request.
- `timeout_o`  out  1  sticky timeout flag; cleared by the next accepted request.
- `conf_req_addr_o`  out  32  RegBus address.
- `conf_req_w_o`  out  1  write strobe: 1 = write, 0 = read.
- `conf_req_wdata_o`  out  32  write data.
- `conf_req_wstrb_o`  out  4  byte strobes; always 4'hF on writes and 4'h0 on reads.
- `conf_req_valid_o`  out  1  request valid.
- `conf_resp_rdata_i`  in  32  read data; valid in the handshake cycle.
- `conf_resp_error_i`  in  1  error response; valid in the handshake cycle.
- `conf_resp_ready_i`  in  1  transaction complete.

## Operation
- States: IDLE, WR_FLUSH, WR_COMMIT, RD_STATUS, GAP, FINISH.
- IDLE:
  - On `flush_req_i`, latch the mask zero-extended to 32 bits as M.
  - Clear `err_o` and `timeout_o`.
  - Go to WR_FLUSH, or to FINISH if M == 0. A zero mask generates no bus traffic.
- WR_FLUSH: write M to `BaseAddr+FlushRegOffset`, then go to WR_COMMIT.
- WR_COMMIT: write 32'h1 to `BaseAddr+CommitRegOffset`, then go to RD_STATUS.
- RD_STATUS: read `BaseAddr+FlushedRegOffset`.
  - If `(rdata & M) == M`, go to FINISH.
  - Otherwise go to GAP.
- GAP: hold `conf_req_valid_o` low for `PollGap` cycles using a down-counter, then return to RD_STATUS.
- FINISH: assert `done_o` for one cycle, then go to IDLE.
- RegBus rules:
  - While valid is high, addr, w, wdata and wstrb are stable until `conf_resp_ready_i`.
  - Valid is never withdrawn before the handshake.
  - A transaction completes in the cycle where valid && ready.
- Error handling: a handshake with `conf_resp_error_i` = 1 in any state sets `err_o`, aborts the remaining steps and goes to FINISH.
- `flush_req_i` while busy is ignored. The mask is not re-sampled.

## Timing
- Reset values: all outputs 0; state IDLE; counters 0.
- Mid-operation reset: outputs drop to 0 immediately (asynchronous); a pending RegBus transaction is abandoned.
- Request accepted at cycle t: `busy_o` and `conf_req_valid_o` for WR_FLUSH rise at t+1. Outputs are driven from registers.
- With ready tied high, each transaction takes 1 cycle and valid is high in back-to-back cycles across WR_FLUSH, WR_COMMIT and RD_STATUS.
- Handshake at cycle h: the next state's valid (or the `done_o` pulse) appears at h+1.
- Best-case latency, request to `done_o`: t+4.
- Zero mask: `done_o` at t+1 and `busy_o` at t+1 only.
- GAP: exactly `PollGap` cycles with valid low between the RD_STATUS handshake and the next read request.

## Configuration
- `LLC_FLUSH_SEQ_TIMEOUT_EN` defined:
  - A counter starts at the WR_COMMIT handshake and counts every cycle thereafter.
  - On reaching `TimeoutCycles` while in RD_STATUS or GAP, set `timeout_o` and go to FINISH. A pending read is first completed at its handshake; its data is ignored.
- Not defined: polling is unbounded, the counter is not instantiated, and `timeout_o` is tied to 0.

## Test plan
- Mask 8'h05, ready always 1, first status read returns 32'h5:
  - write 0x5 to 0x10, write 0x1 to 0x18, read 0x20;
  - `done_o` at t+4; `err_o` = 0.
- Mask 8'h03, status reads return 32'h1, 32'h1, then 32'h3, `PollGap` = 16:
  - three reads, each separated by exactly 16 valid-low cycles;
  - `done_o` one cycle after the third read.
- Ready stalled 5 cycles on the commit write:
  - addr 0x18, wdata 0x1 and valid held stable for all 6 cycles;
  - no extra transaction issued.
- Error on the flush write: `err_o` = 1, no commit write issued, `done_o` pulses; the next request clears `err_o`.
- Mask 0: no RegBus valid at any time; `busy_o` and `done_o` are high in cycle t+1 only.
- With `LLC_FLUSH_SEQ_TIMEOUT_EN` defined, `TimeoutCycles` = 100 and status always 0: `timeout_o` = 1 and `done_o` pulses within 100+`PollGap`+2 cycles of the commit handshake.

Source files
------------

// File: rtl/llc_flush_seq.sv
// llc_flush_seq: flushes a set of LLC ways over the RegBus configuration port.
// It writes the way mask to the flush register, then writes the commit register,
// then polls the flushed-status register until every requested way reads back as
// flushed.
// Optional feature: define LLC_FLUSH_SEQ_TIMEOUT_EN to bound polling by TimeoutCycles.
module llc_flush_seq #(
  parameter int unsigned SetAssociativity = 8,
  parameter logic [31:0] BaseAddr         = 32'h0,
  parameter logic [31:0] FlushRegOffset   = 32'h10,
  parameter logic [31:0] CommitRegOffset  = 32'h18,
  parameter logic [31:0] FlushedRegOffset = 32'h20,
  parameter int unsigned PollGap          = 16
`ifdef LLC_FLUSH_SEQ_TIMEOUT_EN
  ,
  parameter int unsigned TimeoutCycles    = 4096
`endif
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        flush_req_i,
  input  logic [SetAssociativity-1:0] flush_mask_i,
  output logic                        busy_o,
  output logic                        done_o,
  output logic                        err_o,
  output logic                        timeout_o,
  output logic [31:0]                 conf_req_addr_o,
  output logic                        conf_req_w_o,
  output logic [31:0]                 conf_req_wdata_o,
  output logic [3:0]                  conf_req_wstrb_o,
  output logic                        conf_req_valid_o,
  input  logic [31:0]                 conf_resp_rdata_i,
  input  logic                        conf_resp_error_i,
  input  logic                        conf_resp_ready_i
);

  // Gap counter holds PollGap-1 down to 0.
  localparam int unsigned GapW = (PollGap > 1) ? $clog2(PollGap) : 1;

  typedef enum logic [2:0] {
    StIdle,
    StWrFlush,
    StWrCommit,
    StRdStatus,
    StGap,
    StFinish
  } state_e;

  state_e            state_q, state_d;
  logic [31:0]       mask_q, mask_d;
  logic [GapW-1:0]   gap_q, gap_d;
  logic              err_q, err_d;
  logic              tmo_q, tmo_d;
  logic              hs;
  logic              tmo_hit;

  assign hs = conf_req_valid_o & conf_resp_ready_i;

`ifdef LLC_FLUSH_SEQ_TIMEOUT_EN
  logic [31:0] tcnt_q, tcnt_d;

  assign tmo_hit = (tcnt_q >= 32'(TimeoutCycles));

  // Cycles elapsed since the commit handshake; saturates once the budget is hit.
  always_comb begin
    tcnt_d = '0;
    if (state_q == StWrCommit) begin
      if (hs && !conf_resp_error_i) tcnt_d = 32'd1;
    end else if (state_q == StRdStatus || state_q == StGap) begin
      tcnt_d = tmo_hit ? tcnt_q : tcnt_q + 32'd1;
    end
  end

  // Poll budget counter.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) tcnt_q <= '0;
    else       tcnt_q <= tcnt_d;
  end
`else
  assign tmo_hit = 1'b0;
`endif

  // Next-state logic: sequence the three register accesses and the poll loop.
  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    gap_d   = gap_q;
    err_d   = err_q;
    tmo_d   = tmo_q;
    unique case (state_q)
      StIdle: begin
        if (flush_req_i) begin
          mask_d  = 32'(flush_mask_i);
          err_d   = 1'b0;
          tmo_d   = 1'b0;
          state_d = (flush_mask_i == '0) ? StFinish : StWrFlush;
        end
      end
      StWrFlush: begin
        if (hs) begin
          if (conf_resp_error_i) begin
            err_d   = 1'b1;
            state_d = StFinish;
          end else begin
            state_d = StWrCommit;
          end
        end
      end
      StWrCommit: begin
        if (hs) begin
          if (conf_resp_error_i) begin
            err_d   = 1'b1;
            state_d = StFinish;
          end else begin
            state_d = StRdStatus;
          end
        end
      end
      StRdStatus: begin
        if (hs) begin
          if (conf_resp_error_i) begin
            err_d   = 1'b1;
            state_d = StFinish;
          end else if (tmo_hit) begin
            // Budget ran out while the read was pending; its data is discarded.
            tmo_d   = 1'b1;
            state_d = StFinish;
          end else if ((conf_resp_rdata_i & mask_q) == mask_q) begin
            state_d = StFinish;
          end else begin
            gap_d   = GapW'(PollGap - 1);
            state_d = StGap;
          end
        end
      end
      StGap: begin
        if (tmo_hit) begin
          tmo_d   = 1'b1;
          state_d = StFinish;
        end else if (gap_q == '0) begin
          state_d = StRdStatus;
        end else begin
          gap_d = gap_q - 1'b1;
        end
      end
      StFinish: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // State and flag registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      mask_q  <= '0;
      gap_q   <= '0;
      err_q   <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      gap_q   <= gap_d;
      err_q   <= err_d;
      tmo_q   <= tmo_d;
    end
  end

  // RegBus request fields decoded from the registered state only, so they stay
  // stable for the whole time a request waits for ready.
  always_comb begin
    conf_req_valid_o = 1'b0;
    conf_req_w_o     = 1'b0;
    conf_req_addr_o  = '0;
    conf_req_wdata_o = '0;
    conf_req_wstrb_o = 4'h0;
    unique case (state_q)
      StWrFlush: begin
        conf_req_valid_o = 1'b1;
        conf_req_w_o     = 1'b1;
        conf_req_addr_o  = BaseAddr + FlushRegOffset;
        conf_req_wdata_o = mask_q;
        conf_req_wstrb_o = 4'hF;
      end
      StWrCommit: begin
        conf_req_valid_o = 1'b1;
        conf_req_w_o     = 1'b1;
        conf_req_addr_o  = BaseAddr + CommitRegOffset;
        conf_req_wdata_o = 32'h1;
        conf_req_wstrb_o = 4'hF;
      end
      StRdStatus: begin
        conf_req_valid_o = 1'b1;
        conf_req_addr_o  = BaseAddr + FlushedRegOffset;
      end
      default: ;
    endcase
  end

  assign busy_o    = (state_q != StIdle);
  assign done_o    = (state_q == StFinish);
  assign err_o     = err_q;
  assign timeout_o = tmo_q;

endmodule
